// File: rtl/exponent_pkg.sv
// Shared definitions for the exponent engine: FSM states and default widths.
package exponent_pkg;

  localparam int unsigned W_DEFAULT = 32;
  localparam int unsigned E_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage : exponent_pkg

// File: rtl/exp_mul.sv
// Combinational unsigned multiplier, W x W -> 2W.
// Ports: a_i, b_i  operands (W bits)
//        prod_o    full-width product (2W bits)
module exp_mul #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] prod_o
);

  // Zero-extend both operands so the product is formed at full 2W width.
  assign prod_o = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};

endmodule : exp_mul

// File: rtl/exponent_engine.sv
// Sequential x^a mod 2^W using right-to-left square-and-multiply, one exponent
// bit per cycle, with a sticky flag when the true result exceeds W bits.
// Ports: clock, reset_n  rising-edge clock, synchronous active-low reset
//        start, x, a     request and operands (sampled when in_ready)
//        in_ready        engine idle, start accepted this cycle
//        p, overflow     result and overflow flag, valid while p_valid
//        p_valid, p_ready result handshake
module exponent_engine
  import exponent_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT,
  parameter int unsigned E = E_DEFAULT
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [E-1:0] a,
  output logic         in_ready,
  output logic [W-1:0] p,
  output logic         overflow,
  output logic         p_valid,
  input  logic         p_ready
);

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   base_q, base_d;
  logic [E-1:0]   e_q, e_d;
  logic [W-1:0]   p_q, p_d;
  logic           ovf_q, ovf_d;
  logic           pv_q, pv_d;

  logic [2*W-1:0] mul_acc;
  logic [2*W-1:0] mul_sq;

  // acc*base for the multiply step, base*base for the square step.
  exp_mul #(.W(W)) u_mul_acc (
    .a_i    (acc_q),
    .b_i    (base_q),
    .prod_o (mul_acc)
  );

  exp_mul #(.W(W)) u_mul_sq (
    .a_i    (base_q),
    .b_i    (base_q),
    .prod_o (mul_sq)
  );

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= W'(1);
      base_q  <= '0;
      e_q     <= '0;
      p_q     <= W'(1);
      ovf_q   <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      e_q     <= e_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
      pv_q    <= pv_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    e_d     = e_q;
    p_d     = p_q;
    ovf_d   = ovf_q;
    pv_d    = pv_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = x;
          e_d     = a;
          acc_d   = W'(1);
          ovf_d   = 1'b0;
          state_d = COMPUTE;
        end
      end

      COMPUTE: begin
        if (e_q == '0) begin
          p_d     = acc_q;
          pv_d    = 1'b1;
          state_d = DONE;
        end else begin
          if (e_q[0]) begin
            acc_d = mul_acc[W-1:0];
            if (mul_acc[2*W-1:W] != '0) ovf_d = 1'b1;
          end
          base_d = mul_sq[W-1:0];
          // A square only matters if a higher exponent bit will consume it.
          if (((e_q >> 1) != '0) && (mul_sq[2*W-1:W] != '0)) ovf_d = 1'b1;
          e_d = e_q >> 1;
        end
      end

      DONE: begin
        if (p_ready) begin
          pv_d    = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign p        = p_q;
  assign overflow = ovf_q;
  assign p_valid  = pv_q;

endmodule : exponent_engine

// File: tb/tb_exponent_engine.sv
// Directed scoreboard bench for exponent_engine (W=E=32).
module tb_exponent_engine;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] x;
  logic [31:0] a;
  logic        in_ready;
  logic [31:0] p;
  logic        overflow;
  logic        p_valid;
  logic        p_ready;

  int tests;
  int fails;

  typedef struct {
    logic [31:0] p;
    logic        ovf;
    int          lat;
  } sb_item_t;

  sb_item_t sb_q[$];

  exponent_engine #(.W(32), .E(32)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .x        (x),
    .a        (a),
    .in_ready (in_ready),
    .p        (p),
    .overflow (overflow),
    .p_valid  (p_valid),
    .p_ready  (p_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain repeated multiplication; overflow once the exact value leaves 32 bits.
  function automatic sb_item_t model(input logic [31:0] bx, input logic [31:0] ea);
    sb_item_t    it;
    logic [63:0] prod;
    logic [31:0] acc;
    int          bl;
    acc    = 32'd1;
    it.ovf = 1'b0;
    for (int i = 0; i < int'(ea); i++) begin
      prod = {32'd0, acc} * {32'd0, bx};
      if (prod[63:32] != 32'd0) it.ovf = 1'b1;
      acc = prod[31:0];
    end
    bl = 0;
    for (int i = 0; i < 32; i++) if (ea[i]) bl = i + 1;
    it.p   = acc;
    it.lat = bl + 1;
    return it;
  endfunction

  // Drive one request through the accept edge; leaves time at #1 after that edge.
  task automatic issue(input logic [31:0] bx, input logic [31:0] ea);
    check("in_ready_before_start", 64'(in_ready), 64'd1);
    start = 1'b1;
    x     = bx;
    a     = ea;
    @(posedge clock);
    #1;
    start = 1'b0;
    x     = 32'hDEAD_BEEF;
    a     = 32'h0000_00FF;
  endtask

  // Wait for p_valid (bounded), then compare against the scoreboard head.
  task automatic collect(input string tag);
    sb_item_t exp_it;
    int       lat;
    lat = 0;
    while (!p_valid && lat < 64) begin
      @(posedge clock);
      #1;
      lat++;
    end
    if (sb_q.size() == 0) begin
      exp_it.p   = 32'hFFFF_FFFF;
      exp_it.ovf = 1'b1;
      exp_it.lat = -1;
    end else begin
      exp_it = sb_q.pop_front();
    end
    check({tag, "_p_valid"}, 64'(p_valid), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_it.lat));
    check({tag, "_p"}, 64'(p), 64'(exp_it.p));
    check({tag, "_overflow"}, 64'(overflow), 64'(exp_it.ovf));
  endtask

  task automatic consume(input string tag);
    p_ready = 1'b1;
    @(posedge clock);
    #1;
    p_ready = 1'b0;
    check({tag, "_p_valid_cleared"}, 64'(p_valid), 64'd0);
    check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] bx, input logic [31:0] ea);
    sb_q.push_back(model(bx, ea));
    issue(bx, ea);
    collect(tag);
    consume(tag);
  endtask

  initial begin
    sb_item_t it;
    logic     seen;
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    x       = '0;
    a       = '0;
    p_ready = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_p", 64'(p), 64'd1);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_p_valid", 64'(p_valid), 64'd0);

    // Basic, zero-exponent and power-of-two boundaries.
    run("3pow5", 32'd3, 32'd5);
    run("7pow0", 32'd7, 32'd0);
    run("0pow0", 32'd0, 32'd0);
    run("2pow31", 32'd2, 32'd31);
    run("2pow32", 32'd2, 32'd32);
    run("10pow9", 32'd10, 32'd9);
    run("10pow10", 32'd10, 32'd10);
    run("0pow7", 32'd0, 32'd7);

    // Full-width exponent: 1^(2^32-1) = 1 after 33 cycles.
    it.p   = 32'd1;
    it.ovf = 1'b0;
    it.lat = 33;
    sb_q.push_back(it);
    issue(32'd1, 32'hFFFF_FFFF);
    collect("1powmax");
    consume("1powmax");

    // Backpressure: result held, further starts ignored.
    sb_q.push_back(model(32'd3, 32'd5));
    issue(32'd3, 32'd5);
    collect("bp");
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      x     = 32'd99 + 32'(i);
      a     = 32'd1;
      @(posedge clock);
      #1;
      check("bp_hold_p", 64'(p), 64'd243);
      check("bp_hold_p_valid", 64'(p_valid), 64'd1);
      check("bp_no_accept", 64'(in_ready), 64'd0);
    end
    start = 1'b0;
    consume("bp");

    // Reset during the fifth COMPUTE cycle of a long computation.
    issue(32'd3, 32'h0000_FFFF);
    repeat (4) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_p", 64'(p), 64'd1);
    check("rst_mid_p_valid", 64'(p_valid), 64'd0);
    check("rst_mid_overflow", 64'(overflow), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (p_valid) seen = 1'b1;
    end
    check("rst_mid_no_result", 64'(seen), 64'd0);
    run("5pow2", 32'd5, 32'd2);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_exponent_engine
